// File: rtl/msg_stream_parser.sv
// Parses little-endian framed messages (u16 count, then {u16 length, payload}) from an AXI-Stream bus.
// Defining MSG_STREAM_PARSER_STATS_EN adds saturating stat_msgs/stat_errs counters.
module msg_stream_parser #(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [8*DATA_BYTES-1:0]    s_tdata,
  input  logic [DATA_BYTES-1:0]      s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_terror,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [15:0]                msg_length,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic                       err_valid,
  output logic [1:0]                 err_code
`ifdef MSG_STREAM_PARSER_STATS_EN
  ,
  output logic [31:0]                stat_msgs,
  output logic [15:0]                stat_errs
`endif
);

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TRUNC   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {CNT_LO, CNT_HI, LEN_LO, LEN_HI, PAYLOAD, END, DRAIN} state_t;

  state_t                     state_reg, state_next;
  logic [15:0]                cnt_reg, cnt_next;
  logic [15:0]                len_reg, len_next;
  logic [15:0]                pos_reg, pos_next;
  logic [8*MAX_MSG_BYTES-1:0] buf_reg, buf_next, done_buf;
  logic [15:0]                done_len;
  logic [7:0]                 lane_byte [DATA_BYTES];
  logic                       beat_fire, done, err_byte, err_any, emit;
  logic [1:0]                 byte_code, code_next;

  // Single output slot: a new beat may enter only if the held message leaves this cycle.
  assign s_tready  = rst & ~(msg_valid & ~msg_ready);
  assign beat_fire = s_tvalid & s_tready;

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign lane_byte[gi] = s_tdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    pos_next   = pos_reg;
    buf_next   = buf_reg;
    done_buf   = '0;
    done_len   = '0;
    done       = 1'b0;
    err_byte   = 1'b0;
    byte_code  = 2'd0;
    err_any    = 1'b0;
    code_next  = 2'd0;
    if (beat_fire) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (s_tkeep[k]) begin
          case (state_next)
            CNT_LO: begin
              cnt_next[7:0] = lane_byte[k];
              state_next    = CNT_HI;
            end
            CNT_HI: begin
              cnt_next[15:8] = lane_byte[k];
              state_next     = (cnt_next == 16'd0) ? END : LEN_LO;
            end
            LEN_LO: begin
              len_next[7:0] = lane_byte[k];
              state_next    = LEN_HI;
            end
            LEN_HI: begin
              len_next[15:8] = lane_byte[k];
              if (len_next < 16'(MIN_MSG_BYTES) || len_next > 16'(MAX_MSG_BYTES)) begin
                err_byte   = 1'b1;
                byte_code  = ERR_LEN;
                state_next = DRAIN;
              end else begin
                pos_next   = '0;
                buf_next   = '0;
                state_next = PAYLOAD;
              end
            end
            PAYLOAD: begin
              for (int i = 0; i < MAX_MSG_BYTES; i++) begin
                if (pos_next == 16'(i)) buf_next[8*i +: 8] = lane_byte[k];
              end
              pos_next = pos_next + 16'd1;
              // Snapshot now: the next header may start later in this same beat.
              if (pos_next == len_next) begin
                done       = 1'b1;
                done_len   = len_next;
                done_buf   = buf_next;
                cnt_next   = cnt_next - 16'd1;
                state_next = (cnt_next == 16'd0) ? END : LEN_LO;
              end
            end
            END: begin
              err_byte   = 1'b1;
              byte_code  = ERR_OVERRUN;
              state_next = DRAIN;
            end
            default: ;
          endcase
        end
      end
      if (err_byte) begin
        err_any   = 1'b1;
        code_next = byte_code;
      end else if (s_terror && state_reg != DRAIN) begin
        err_any   = 1'b1;
        code_next = ERR_OVERRUN;
      end
      if (s_terror) state_next = DRAIN;
      if (s_tlast) begin
        if (!err_any && state_next != END && state_next != DRAIN) begin
          err_any   = 1'b1;
          code_next = ERR_TRUNC;
        end
        state_next = CNT_LO;
      end
    end
  end

  assign emit = done & ~err_byte & ~s_terror;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= CNT_LO;
      cnt_reg    <= '0;
      len_reg    <= '0;
      pos_reg    <= '0;
      buf_reg    <= '0;
      msg_valid  <= 1'b0;
      msg_length <= '0;
      msg_data   <= '0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      pos_reg   <= pos_next;
      buf_reg   <= buf_next;
      err_valid <= err_any;
      err_code  <= code_next;
      if (emit) begin
        msg_valid  <= 1'b1;
        msg_length <= done_len;
        msg_data   <= done_buf;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

`ifdef MSG_STREAM_PARSER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_msgs <= '0;
      stat_errs <= '0;
    end else begin
      if (msg_valid && msg_ready && stat_msgs != '1) stat_msgs <= stat_msgs + 32'd1;
      if (err_valid && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_stream_parser.sv
// Randomized bench for msg_stream_parser: frames are parsed by a byte-level reference model and the
// resulting message/error queues are compared against the DUT outputs.
module tb_msg_stream_parser;
  localparam int DB   = 8;
  localparam int MAXB = 32;
  localparam int MINB = 8;

  typedef byte unsigned bytes_t[$];
  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; logic err; } beat_t;
  typedef struct { logic [15:0] len; logic [255:0] data; } msg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_terror = 1'b0;
  logic          msg_valid;
  logic          msg_ready = 1'b0;
  logic [15:0]   msg_length;
  logic [255:0]  msg_data;
  logic          err_valid;
  logic [1:0]    err_code;
`ifdef MSG_STREAM_PARSER_STATS_EN
  logic [31:0]   stat_msgs;
  logic [15:0]   stat_errs;
`endif

  msg_stream_parser #(.DATA_BYTES(DB), .MAX_MSG_BYTES(MAXB), .MIN_MSG_BYTES(MINB)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_terror(s_terror),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_length(msg_length), .msg_data(msg_data),
    .err_valid(err_valid), .err_code(err_code)
`ifdef MSG_STREAM_PARSER_STATS_EN
    , .stat_msgs(stat_msgs), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int      total = 0;
  int      bad = 0;
  int      ready_mode = 1;
  bit      accepted = 0, popped = 0, held = 0, obs_valid = 0, lat_check = 0;
  logic [255:0] held_data;
  logic [15:0]  held_len;
  beat_t   beat_q[$];
  beat_t   last_popped;
  msg_t    exp_msgs[$];
  int      exp_errs[$];
  bytes_t  fb;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void add_word(input logic [63:0] w, input int n);
    for (int k = 0; k < n; k++) fb.push_back(8'(w >> (8*k)));
  endfunction

  // Parse a whole frame from its bytes; the first error wins, messages finishing before that error's beat survive.
  function automatic void model(input bytes_t b, input int tbeat);
    int sz = b.size();
    int last = (sz + DB - 1) / DB - 1;
    int eb = 1 << 30;
    int code = 0;
    int p, cnt, len;
    msg_t got[$];
    int gb[$];
    msg_t m;
    if (sz < 2) begin
      eb = last; code = 2;
    end else begin
      cnt = int'(b[0]) + 256 * int'(b[1]);
      p = 2;
      for (int i = 0; i < cnt && code == 0; i++) begin
        if (p + 2 > sz) begin
          eb = last; code = 2;
        end else begin
          len = int'(b[p]) + 256 * int'(b[p+1]);
          if (len < MINB || len > MAXB) begin
            eb = (p + 1) / DB; code = 1;
          end else if (p + 2 + len > sz) begin
            eb = last; code = 2;
          end else begin
            m.len = 16'(len);
            m.data = '0;
            for (int j = 0; j < len; j++) m.data = m.data | (256'(b[p+2+j]) << (8*j));
            got.push_back(m);
            gb.push_back((p + 1 + len) / DB);
            p = p + 2 + len;
          end
        end
      end
      if (code == 0 && p < sz) begin
        eb = p / DB; code = 3;
      end
    end
    if (tbeat >= 0 && (tbeat < eb || (tbeat == eb && code == 2))) begin
      eb = tbeat; code = 3;
    end
    foreach (got[i]) if (code == 0 || code == 2 || gb[i] < eb) exp_msgs.push_back(got[i]);
    if (code != 0) exp_errs.push_back(code);
  endfunction

  task automatic send(input bytes_t b, input int tbeat, input bit use_model);
    int nb = (b.size() + DB - 1) / DB;
    beat_t bt;
    if (use_model) model(b, tbeat);
    for (int i = 0; i < nb; i++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int k = 0; k < DB; k++) begin
        if (i*DB + k < b.size()) begin
          bt.data = bt.data | (64'(b[i*DB+k]) << (8*k));
          bt.keep = bt.keep | (8'(1) << k);
        end
      end
      bt.last = (i == nb - 1);
      bt.err  = (i == tbeat);
      beat_q.push_back(bt);
    end
  endtask

  task automatic cycle();
    msg_t e;
    @(negedge clk);
    if (err_valid) begin
      if (exp_errs.size() == 0) chk("err_extra", 256'(err_valid), 256'(0));
      else chk("err_code", 256'(err_code), 256'(exp_errs.pop_front()));
    end else begin
      chk("err_idle", 256'(err_code), 256'(0));
    end
    case (ready_mode)
      0:       msg_ready = ($urandom_range(0, 3) != 0);
      1:       msg_ready = 1'b1;
      default: msg_ready = 1'b0;
    endcase
    if (held) begin
      chk("hold_valid", 256'(msg_valid), 256'(1));
      chk("hold_data", msg_data, held_data);
      chk("hold_len", 256'(msg_length), 256'(held_len));
    end
    if (msg_valid && msg_ready) begin
      if (exp_msgs.size() == 0) chk("msg_extra", 256'(msg_valid), 256'(0));
      else begin
        e = exp_msgs.pop_front();
        chk("msg_len", 256'(msg_length), 256'(e.len));
        chk("msg_data", msg_data, e.data);
        $display("msg len=%0d data=%h", msg_length, msg_data);
      end
    end
    held      = msg_valid && !msg_ready;
    held_data = msg_data;
    held_len  = msg_length;
    obs_valid = msg_valid;
    popped    = accepted;
    if (accepted) last_popped = beat_q.pop_front();
    if (lat_check && popped && last_popped.last) chk("t1_latency", 256'(obs_valid), 256'(1));
    if (beat_q.size() > 0) begin
      s_tvalid = 1'b1;
      s_tdata  = beat_q[0].data;
      s_tkeep  = beat_q[0].keep;
      s_tlast  = beat_q[0].last;
      s_terror = beat_q[0].err;
    end else begin
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_terror = 1'b0;
    end
    #1;
    accepted = s_tvalid && s_tready;
  endtask

  task automatic run_idle();
    int n = 0;
    while ((beat_q.size() > 0 || msg_valid) && n < 20000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 256'(n < 20000), 256'(1));
    repeat (3) cycle();
  endtask

  task automatic rand_frame();
    int cnt, len, nb, tb, keep_n;
    fb.delete();
    cnt = $urandom_range(0, 3);
    fb.push_back(8'(cnt));
    fb.push_back(8'd0);
    for (int m = 0; m < cnt; m++) begin
      if ($urandom_range(0, 9) == 0)
        len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(33, 40));
      else
        len = $urandom_range(MINB, MAXB);
      fb.push_back(8'(len));
      fb.push_back(8'd0);
      for (int j = 0; j < len; j++) fb.push_back(8'($urandom));
    end
    case ($urandom_range(0, 9))
      0, 1: begin
        keep_n = $urandom_range(1, fb.size() - 1);
        while (fb.size() > keep_n) void'(fb.pop_back());
      end
      2: repeat ($urandom_range(1, 5)) fb.push_back(8'($urandom));
      default: ;
    endcase
    nb = (fb.size() + DB - 1) / DB;
    tb = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
    send(fb, tb, 1'b1);
  endtask

  task automatic frame_t1();
    fb.delete();
    add_word(64'habcddcef_00080001, 8);
    add_word(64'h630d658d, 4);
  endtask

  task automatic frame_t2();
    fb.delete();
    add_word(64'h045de506_000e0002, 8);
    add_word(64'h03889560_84130858, 8);
    add_word(64'h85468052_0008a5b0, 8);
    add_word(64'hd845a30c, 4);
  endtask

  initial begin
    beat_t pb;
    #3;
    chk("rst_tready", 256'(s_tready), 256'(0));
    chk("rst_msg_valid", 256'(msg_valid), 256'(0));
    chk("rst_err_valid", 256'(err_valid), 256'(0));
    chk("rst_msg_data", msg_data, 256'(0));
    chk("rst_msg_len", 256'(msg_length), 256'(0));
`ifdef MSG_STREAM_PARSER_STATS_EN
    chk("rst_stat_msgs", 256'(stat_msgs), 256'(0));
`endif
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Directed example: literal expectation and one-cycle latency after the final beat.
    ready_mode = 1;
    frame_t1();
    exp_msgs.push_back('{16'd8, 256'h630d658d_abcddcef});
    send(fb, -1, 1'b0);
    lat_check = 1;
    run_idle();
    lat_check = 0;

    frame_t2();
    send(fb, -1, 1'b1);
    run_idle();

    // Consumer stalled: second message must wait with the input held.
    ready_mode = 2;
    frame_t2();
    send(fb, -1, 1'b1);
    repeat (10) cycle();
    chk("t3_tready_low", 256'(s_tready), 256'(0));
    chk("t3_valid_held", 256'(msg_valid), 256'(1));
    ready_mode = 0;
    run_idle();

    // Oversize length, then a good frame.
    fb.delete();
    add_word(64'h55443322_00210001, 8);
    add_word(64'h99887766, 4);
    send(fb, -1, 1'b1);
    frame_t1();
    send(fb, -1, 1'b1);
    run_idle();

    // Early tlast after first message; upstream error mid-payload.
    fb.delete();
    add_word(64'h44332211_00080002, 8);
    add_word(64'h88776655, 4);
    send(fb, -1, 1'b1);
    fb.delete();
    add_word(64'h44332211_00100001, 8);
    add_word(64'h0c0b0a09_08070605, 8);
    add_word(64'h100f0e0d, 4);
    send(fb, 1, 1'b1);
    run_idle();

    ready_mode = 0;
    for (int f = 0; f < 40; f++) rand_frame();
    run_idle();

    // Reset mid-frame with a message pending.
    ready_mode = 2;
    frame_t1();
    send(fb, -1, 1'b0);
    pb.data = 64'hddccbbaa_00100001; pb.keep = 8'hff; pb.last = 1'b0; pb.err = 1'b0;
    beat_q.push_back(pb);
    repeat (6) cycle();
    chk("t6_pending", 256'(msg_valid), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("t6_msg_valid", 256'(msg_valid), 256'(0));
    chk("t6_msg_data", msg_data, 256'(0));
    chk("t6_tready", 256'(s_tready), 256'(0));
    chk("t6_err_valid", 256'(err_valid), 256'(0));
`ifdef MSG_STREAM_PARSER_STATS_EN
    chk("t6_stat_msgs", 256'(stat_msgs), 256'(0));
    chk("t6_stat_errs", 256'(stat_errs), 256'(0));
`endif
    beat_q.delete();
    accepted = 0;
    held = 0;
    s_tvalid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    ready_mode = 1;
    frame_t1();
    send(fb, -1, 1'b1);
    run_idle();
`ifdef MSG_STREAM_PARSER_STATS_EN
    chk("t6_stat_after", 256'(stat_msgs), 256'(1));
`endif

    chk("msgs_left", 256'(exp_msgs.size()), 256'(0));
    chk("errs_left", 256'(exp_errs.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
